// File: rtl/zbuf_rmw_ctrl_if.sv
// Fragment, clear-control and depth-memory signals of the Z-buffer RMW sequencer.
// Pure wiring; no latency of its own.
// frag_valid/frag_ready carry backpressure; the memory side has no stall.
interface zbuf_rmw_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              frag_valid;
  logic              frag_ready;
  logic [ADDR_W-1:0] frag_addr;
  logic [17:0]       frag_z;
  logic [15:0]       frag_color;

  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic [17:0]       mem_rdata_z;
  logic              mem_wren;
  logic [17:0]       mem_wdata_z;
  logic [15:0]       mem_wdata_color;

  // Environment side: shader output, clear requester and the depth memory
  modport master (
    output frag_valid, frag_addr, frag_z, frag_color, clear_req, mem_rdata_z,
    input  frag_ready, clear_busy, clear_done,
    input  mem_addr, mem_rden, mem_wren, mem_wdata_z, mem_wdata_color
  );

  // Sequencer side
  modport slave (
    input  frag_valid, frag_addr, frag_z, frag_color, clear_req, mem_rdata_z,
    output frag_ready, clear_busy, clear_done,
    output mem_addr, mem_rden, mem_wren, mem_wdata_z, mem_wdata_color
  );
endinterface

// File: rtl/zbuf_rmw_ctrl.sv
// Depth-buffer read-modify-write sequencer with built-in full-frame clear sweep.
// Latency: read strobe 1 cycle after accept, conditional write RD_LAT cycles later.
// frag_ready drops from accept until the fragment's test cycle completes and during clears.
module zbuf_rmw_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int NUM_PIXELS = 307200,
  parameter int RD_LAT     = 2
) (
  input  logic          clk,
  input  logic          reset,
  zbuf_rmw_ctrl_if.slave bus
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, TEST, CLEAR} state_t;

  state_t            state, stateNxt;
  logic [ADDR_W-1:0] clrCnt, clrCntNxt;
  logic [WCW-1:0]    waitCnt, waitCntNxt;
  logic              clearPend, clearPendNxt;
  logic              clearDone, doneNxt;
  logic              loadFrag;
  logic [ADDR_W-1:0] fragAddrQ;
  logic [17:0]       fragZQ;
  logic [15:0]       fragColorQ;
  logic [ADDR_W-1:0] lastAddr, addrOut;
  logic              fragReady;
  logic              rdEn, wrEn, busy;
  logic [17:0]       wrZ;
  logic [15:0]       wrColor;

  // Team float ordering: sign-magnitude, +0 and -0 compare equal; true iff a > b
  function automatic logic zGreater(input logic [17:0] a, input logic [17:0] b);
    logic res;
    res = 1'b0;
    if (a[16:0] == 17'd0 && b[16:0] == 17'd0) begin
      res = 1'b0;
    end else begin
      case ({a[17], b[17]})
        2'b00:   res = (a[16:0] > b[16:0]);
        2'b11:   res = (a[16:0] < b[16:0]);
        2'b01:   res = 1'b1;
        default: res = 1'b0;
      endcase
    end
    return res;
  endfunction

  // State, counters and the clear-pending flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clrCnt    <= '0;
      waitCnt   <= '0;
      clearPend <= 1'b0;
      clearDone <= 1'b0;
      lastAddr  <= '0;
    end else begin
      state     <= stateNxt;
      clrCnt    <= clrCntNxt;
      waitCnt   <= waitCntNxt;
      clearPend <= clearPendNxt;
      clearDone <= doneNxt;
      lastAddr  <= addrOut;
    end
  end

  // Fragment capture on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fragAddrQ  <= '0;
      fragZQ     <= '0;
      fragColorQ <= '0;
    end else if (loadFrag) begin
      fragAddrQ  <= bus.frag_addr;
      fragZQ     <= bus.frag_z;
      fragColorQ <= bus.frag_color;
    end
  end

  // Next-state and memory-port decode; mem_addr holds its last value when idle
  always_comb begin
    stateNxt     = state;
    clrCntNxt    = clrCnt;
    waitCntNxt   = waitCnt;
    clearPendNxt = clearPend;
    doneNxt      = 1'b0;
    loadFrag     = 1'b0;
    fragReady    = 1'b0;
    rdEn         = 1'b0;
    wrEn         = 1'b0;
    busy         = 1'b0;
    addrOut      = lastAddr;
    wrZ          = '0;
    wrColor      = '0;
    case (state)
      IDLE: begin
        if (bus.clear_req || clearPend) begin
          stateNxt     = CLEAR;
          clrCntNxt    = '0;
          clearPendNxt = 1'b0;
        end else begin
          fragReady = 1'b1;
          if (bus.frag_valid) begin
            loadFrag = 1'b1;
            stateNxt = READ;
          end
        end
      end
      READ: begin
        rdEn    = 1'b1;
        addrOut = fragAddrQ;
        if (bus.clear_req) clearPendNxt = 1'b1;
        if (RD_LAT == 1) begin
          stateNxt = TEST;
        end else begin
          stateNxt   = WAIT;
          waitCntNxt = WCW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (bus.clear_req) clearPendNxt = 1'b1;
        if (waitCnt <= WCW'(1)) begin
          stateNxt = TEST;
        end else begin
          waitCntNxt = waitCnt - WCW'(1);
        end
      end
      TEST: begin
        if (bus.clear_req) clearPendNxt = 1'b1;
        wrEn     = zGreater(fragZQ, bus.mem_rdata_z);
        addrOut  = fragAddrQ;
        wrZ      = fragZQ;
        wrColor  = fragColorQ;
        stateNxt = IDLE;
      end
      CLEAR: begin
        wrEn    = 1'b1;
        busy    = 1'b1;
        addrOut = clrCnt;
        if (clrCnt == LAST_PIX) begin
          stateNxt = IDLE;
          doneNxt  = 1'b1;
        end else begin
          clrCntNxt = clrCnt + ADDR_W'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Ready is masked during reset so every output reads 0 while it is held
  assign bus.frag_ready      = fragReady & ~reset;
  assign bus.mem_rden        = rdEn;
  assign bus.mem_wren        = wrEn;
  assign bus.mem_addr        = addrOut;
  assign bus.mem_wdata_z     = wrZ;
  assign bus.mem_wdata_color = wrColor;
  assign bus.clear_busy      = busy;
  assign bus.clear_done      = clearDone;

endmodule

// File: tb/tb_zbuf_rmw_ctrl.sv
// Directed bench for zbuf_rmw_ctrl with a behavioural depth memory (RD_LAT=2, 16-pixel clear).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Memory write/read model responds on the rising edge, like the real RAM.
module tb_zbuf_rmw_ctrl;

  localparam int ADDR_W = 19;
  localparam int NPIX   = 16;
  localparam int RDL    = 2;

  localparam logic [17:0] Z1_0  = 18'h0FC00;
  localparam logic [17:0] Z0_5  = 18'h0F800;
  localparam logic [17:0] Z0_25 = 18'h0F400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zbuf_rmw_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  zbuf_rmw_ctrl #(.ADDR_W(ADDR_W), .NUM_PIXELS(NPIX), .RD_LAT(RDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  logic [17:0] zMem   [0:255];
  logic [15:0] colMem [0:255];
  logic [17:0] p1, p2;
  int cyc = 0;
  int rdCnt = 0;
  int wrCnt = 0;
  int checks = 0;
  int failures = 0;
  int t0, a0, a1, doneCyc, accCyc, w0, r0;
  logic got;

  assign ifc.mem_rdata_z = p2;

  // Depth memory: two-stage read pipeline, synchronous write
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= zMem[ifc.mem_addr[7:0]];
    p2  <= p1;
    if (ifc.mem_wren) begin
      zMem[ifc.mem_addr[7:0]]   <= ifc.mem_wdata_z;
      colMem[ifc.mem_addr[7:0]] <= ifc.mem_wdata_color;
    end
  end

  // Strobe counters
  always @(negedge clk) begin
    if (ifc.mem_rden) rdCnt <= rdCnt + 1;
    if (ifc.mem_wren) wrCnt <= wrCnt + 1;
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one fragment from IDLE and let it run through TEST
  task automatic runFrag(input logic [ADDR_W-1:0] a, input logic [17:0] z, input logic [15:0] c);
    step();
    ifc.frag_valid = 1'b1;
    ifc.frag_addr  = a;
    ifc.frag_z     = z;
    ifc.frag_color = c;
    @(negedge clk);
    checkVal("frag_accept", ifc.frag_ready, 1);
    step();
    ifc.frag_valid = 1'b0;
    repeat (RDL + 1) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ifc.frag_valid = 1'b0;
    ifc.frag_addr  = '0;
    ifc.frag_z     = '0;
    ifc.frag_color = '0;
    ifc.clear_req  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      zMem[i]   = '0;
      colMem[i] = '0;
    end
    zMem[100] = Z0_5;
    zMem[5]   = 18'h01234;

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_ready", ifc.frag_ready, 0);
    checkVal("rst_rden", ifc.mem_rden, 0);
    checkVal("rst_wren", ifc.mem_wren, 0);
    checkVal("rst_busy", ifc.clear_busy, 0);
    checkVal("rst_done", ifc.clear_done, 0);
    checkVal("rst_addr", ifc.mem_addr, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    checkVal("rel_ready", ifc.frag_ready, 1);

    // Passing fragment: 1.0 over stored 0.5 at address 100
    step();
    ifc.frag_valid = 1'b1;
    ifc.frag_addr  = 100;
    ifc.frag_z     = Z1_0;
    ifc.frag_color = 16'hF800;
    @(negedge clk);
    checkVal("t1_accept", ifc.frag_ready, 1);
    step();
    ifc.frag_valid = 1'b0;
    @(negedge clk);
    checkVal("t1_rden", ifc.mem_rden, 1);
    checkVal("t1_rd_addr", ifc.mem_addr, 100);
    checkVal("t1_busy_ready", ifc.frag_ready, 0);
    step();
    @(negedge clk);
    checkVal("t1_wait_rden", ifc.mem_rden, 0);
    checkVal("t1_wait_wren", ifc.mem_wren, 0);
    step();
    @(negedge clk);
    checkVal("t1_wren", ifc.mem_wren, 1);
    checkVal("t1_wr_addr", ifc.mem_addr, 100);
    checkVal("t1_wz", ifc.mem_wdata_z, Z1_0);
    checkVal("t1_wc", ifc.mem_wdata_color, 16'hF800);
    step();
    @(negedge clk);
    checkVal("t1_ready_back", ifc.frag_ready, 1);
    checkVal("t1_mem_z", zMem[100], Z1_0);

    // Equal and smaller depth both fail the test
    w0 = wrCnt;
    r0 = rdCnt;
    runFrag(100, Z1_0, 16'h07E0);
    runFrag(100, Z0_25, 16'h001F);
    step();
    checkVal("t2_no_write", wrCnt - w0, 0);
    checkVal("t2_reads", rdCnt - r0, 2);
    checkVal("t2_mem_z", zMem[100], Z1_0);
    checkVal("t2_mem_c", colMem[100], 16'hF800);

    // Back-to-back with frag_valid held high
    w0 = wrCnt;
    r0 = rdCnt;
    ifc.frag_valid = 1'b1;
    ifc.frag_addr  = 200;
    ifc.frag_z     = Z1_0;
    ifc.frag_color = 16'h1111;
    @(negedge clk);
    checkVal("t3_accept0", ifc.frag_ready, 1);
    a0 = cyc;
    step();
    ifc.frag_addr  = 201;
    ifc.frag_z     = Z0_5;
    ifc.frag_color = 16'h2222;
    got = 1'b0;
    a1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.frag_ready) begin
        got = 1'b1;
        a1  = cyc;
        break;
      end
    end
    checkVal("t3_accept1_seen", got, 1);
    checkVal("t3_gap", a1 - a0, 4);
    step();
    ifc.frag_valid = 1'b0;
    repeat (3) step();
    checkVal("t3_reads", rdCnt - r0, 2);
    checkVal("t3_writes", wrCnt - w0, 2);
    checkVal("t3_mem201", zMem[201], Z0_5);

    // Full clear sweep of 16 pixels
    ifc.clear_req = 1'b1;
    @(negedge clk);
    checkVal("t4_req_ready", ifc.frag_ready, 0);
    step();
    ifc.clear_req = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      checkVal("t4_busy", ifc.clear_busy, 1);
      checkVal("t4_wren", ifc.mem_wren, 1);
      checkVal("t4_addr", ifc.mem_addr, i);
      checkVal("t4_wz", ifc.mem_wdata_z, 0);
      checkVal("t4_wc", ifc.mem_wdata_color, 0);
      checkVal("t4_ready", ifc.frag_ready, 0);
      checkVal("t4_done_early", ifc.clear_done, 0);
      step();
    end
    @(negedge clk);
    checkVal("t4_done", ifc.clear_done, 1);
    checkVal("t4_busy_off", ifc.clear_busy, 0);
    checkVal("t4_wren_off", ifc.mem_wren, 0);
    step();
    @(negedge clk);
    checkVal("t4_done_pulse", ifc.clear_done, 0);
    checkVal("t4_mem5", zMem[5], 0);

    // Clear requested while a fragment waits on its read
    step();
    ifc.frag_valid = 1'b1;
    ifc.frag_addr  = 7;
    ifc.frag_z     = Z0_5;
    ifc.frag_color = 16'hABCD;
    @(negedge clk);
    checkVal("t5_accept", ifc.frag_ready, 1);
    t0 = cyc;
    step();
    ifc.frag_valid = 1'b0;
    step();
    ifc.clear_req  = 1'b1;
    ifc.frag_valid = 1'b1;
    ifc.frag_addr  = 8;
    ifc.frag_z     = Z0_5;
    ifc.frag_color = 16'h5555;
    @(negedge clk);
    checkVal("t5_wait_ready", ifc.frag_ready, 0);
    step();
    ifc.clear_req = 1'b0;
    @(negedge clk);
    checkVal("t5_test_wren", ifc.mem_wren, 1);
    checkVal("t5_test_addr", ifc.mem_addr, 7);
    step();
    @(negedge clk);
    checkVal("t5_idle_busy", ifc.clear_busy, 0);
    checkVal("t5_idle_ready", ifc.frag_ready, 0);
    step();
    @(negedge clk);
    checkVal("t5_clr_busy", ifc.clear_busy, 1);
    checkVal("t5_clr_addr", ifc.mem_addr, 0);
    doneCyc = 0;
    accCyc  = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      @(negedge clk);
      if (ifc.clear_done && doneCyc == 0) doneCyc = cyc;
      if (ifc.frag_ready) begin
        accCyc = cyc;
        break;
      end
    end
    checkVal("t5_done_seen", doneCyc != 0, 1);
    checkVal("t5_accept_at_done", accCyc, doneCyc);
    checkVal("t5_accept_delay", accCyc - t0, 21);
    step();
    ifc.frag_valid = 1'b0;
    repeat (3) step();
    checkVal("t5_mem7_cleared", zMem[7], 0);
    checkVal("t5_mem8_z", zMem[8], Z0_5);
    checkVal("t5_mem8_c", colMem[8], 16'h5555);

    // Reset in the middle of a clear sweep
    zMem[4] = 18'h00003;
    zMem[5] = 18'h00003;
    zMem[6] = 18'h00003;
    ifc.clear_req = 1'b1;
    step();
    ifc.clear_req = 1'b0;
    repeat (5) step();
    @(negedge clk);
    checkVal("t6_at5", ifc.mem_addr, 5);
    #1;
    reset = 1'b1;
    #1;
    checkVal("t6_rst_wren", ifc.mem_wren, 0);
    checkVal("t6_rst_busy", ifc.clear_busy, 0);
    checkVal("t6_rst_addr", ifc.mem_addr, 0);
    checkVal("t6_rst_rden", ifc.mem_rden, 0);
    checkVal("t6_rst_ready", ifc.frag_ready, 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    checkVal("t6_rel_ready", ifc.frag_ready, 1);
    checkVal("t6_mem4", zMem[4], 0);
    checkVal("t6_mem5", zMem[5], 18'h00003);
    checkVal("t6_mem6", zMem[6], 18'h00003);
    step();
    ifc.clear_req = 1'b1;
    step();
    ifc.clear_req = 1'b0;
    @(negedge clk);
    checkVal("t6_restart_busy", ifc.clear_busy, 1);
    checkVal("t6_restart_addr", ifc.mem_addr, 0);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ifc.clear_done) begin
        got = 1'b1;
        break;
      end
    end
    checkVal("t6_restart_done", got, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
